// File: rtl/nyan_audio_pkg.sv
// Shared audio-path types and defaults for the song sequencer and the mixer.
// Songpos and volume widths are fixed by the note-table ROM and the sample scaler.
package nyan_audio_pkg;

    localparam int DEF_SONG_LEN       = 288;
    localparam int DEF_TICKS_PER_BEAT = 6;
    localparam int DEF_VOL_MAX        = 63;
    localparam int POS_W              = 9;
    localparam int VOL_W              = 6;
    localparam int NUM_VOICES         = 2;

    typedef logic [POS_W-1:0] songpos_t;
    typedef logic [VOL_W-1:0] vol_t;

    // One decay step.  v >> shift never exceeds v, so the result cannot underflow.
    function automatic vol_t env_decay_step(input vol_t v, input int shift);
        return v - (v >> shift);
    endfunction

endpackage

// File: rtl/nyan_song_sequencer_if.sv
// Sequencer control/trigger inputs and position/envelope outputs.
interface nyan_song_sequencer_if;

    logic                     frame_tick;
    logic                     hold;
    logic                     restart;
    logic                     melody_trig;
    logic                     bass_trig;
    nyan_audio_pkg::songpos_t songpos;
    nyan_audio_pkg::vol_t     sqr_vol;
    nyan_audio_pkg::vol_t     bass_vol;
    logic                     beat_strobe;
    logic                     loop_strobe;

    modport master (
        output frame_tick, hold, restart, melody_trig, bass_trig,
        input  songpos, sqr_vol, bass_vol, beat_strobe, loop_strobe
    );

    modport slave (
        input  frame_tick, hold, restart, melody_trig, bass_trig,
        output songpos, sqr_vol, bass_vol, beat_strobe, loop_strobe
    );

endinterface

// File: rtl/nyan_env_decay.sv
// One voice envelope: re-arm on a triggered beat, hold on an untriggered beat,
// geometric decay on every other accepted tick.
module nyan_env_decay
    import nyan_audio_pkg::*;
#(
    parameter int SHIFT   = 3,
    parameter int VOL_MAX = DEF_VOL_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic trig,
    input  logic beat,
    input  logic clr,
    output vol_t vol
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vol <= '0;
        end else if (clr) begin
            vol <= '0;
        end else if (tick) begin
            if (beat) begin
                if (trig)
                    vol <= vol_t'(VOL_MAX);
            end else begin
                vol <= env_decay_step(vol, SHIFT);
            end
        end
    end

endmodule

// File: rtl/nyan_song_sequencer.sv
// Frame-tick song sequencer: counts ticks into beats, steps the looping song
// position and drives the per-voice envelopes.
module nyan_song_sequencer
    import nyan_audio_pkg::*;
#(
    parameter int SONG_LEN       = DEF_SONG_LEN,
    parameter int TICKS_PER_BEAT = DEF_TICKS_PER_BEAT,
    parameter int VOL_MAX        = DEF_VOL_MAX,
    parameter int SQR_SHIFT      = 3,
    parameter int BASS_SHIFT     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    nyan_song_sequencer_if.slave  bus
);

    logic [2:0]                  tick_ctr;
    logic [3:0]                  tick_next;
    songpos_t                    songpos;
    logic                        beat_strobe;
    logic                        loop_strobe;
    logic                        accept;
    logic                        beat;
    logic                        at_end;
    logic [NUM_VOICES-1:0]       trig;
    vol_t [NUM_VOICES-1:0]       vol;

    // restart beats both hold and a coincident tick
    assign accept    = bus.frame_tick & ~bus.hold & ~bus.restart;
    assign tick_next = {1'b0, tick_ctr} + 4'd1;
    assign beat      = accept && (tick_next == 4'(TICKS_PER_BEAT));
    assign at_end    = (songpos == songpos_t'(SONG_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_ctr    <= '0;
            songpos     <= songpos_t'(SONG_LEN - 1);
            beat_strobe <= 1'b0;
            loop_strobe <= 1'b0;
        end else if (bus.restart) begin
            tick_ctr    <= '0;
            songpos     <= songpos_t'(SONG_LEN - 1);
            beat_strobe <= 1'b0;
            loop_strobe <= 1'b0;
        end else begin
            beat_strobe <= 1'b0;
            loop_strobe <= 1'b0;
            if (beat) begin
                tick_ctr    <= '0;
                songpos     <= at_end ? '0 : songpos + songpos_t'(1);
                beat_strobe <= 1'b1;
                loop_strobe <= at_end;
            end else if (accept) begin
                tick_ctr <= tick_next[2:0];
            end
        end
    end

    // Voice 0 is the square melody, voice 1 the bass.
    assign trig = {bus.bass_trig, bus.melody_trig};

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        localparam int SH = (v == 0) ? SQR_SHIFT : BASS_SHIFT;
        nyan_env_decay #(
            .SHIFT   (SH),
            .VOL_MAX (VOL_MAX)
        ) u_env (
            .clk   (clk),
            .reset (reset),
            .tick  (accept),
            .trig  (trig[v]),
            .beat  (beat),
            .clr   (bus.restart),
            .vol   (vol[v])
        );
    end

    assign bus.songpos     = songpos;
    assign bus.sqr_vol     = vol[0];
    assign bus.bass_vol    = vol[1];
    assign bus.beat_strobe = beat_strobe;
    assign bus.loop_strobe = loop_strobe;

endmodule

// File: tb/tb_nyan_song_sequencer.sv
// Directed bench: the driver pushes expected post-edge state into a queue,
// a monitor pops and compares one entry per clock.
module tb_nyan_song_sequencer;
    import nyan_audio_pkg::*;

    typedef struct {
        songpos_t pos;
        vol_t     sv;
        vol_t     bv;
        logic     bs;
        logic     ls;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_beat = 0;
    int   n_loop = 0;
    exp_t q[$];

    int m_pos  = 287;
    int m_tick = 0;
    int m_sv   = 0;
    int m_bv   = 0;
    int m_bs   = 0;
    int m_ls   = 0;

    nyan_song_sequencer_if bus();

    nyan_song_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 287; m_tick = 0; m_sv = 0; m_bv = 0; m_bs = 0; m_ls = 0;
    endtask

    // Drive one cycle of inputs, then record the state expected after that edge.
    task automatic step(input logic ft, input logic h, input logic rs,
                        input logic mt, input logic bt);
        exp_t e;
        @(negedge clk);
        bus.frame_tick  = ft;
        bus.hold        = h;
        bus.restart     = rs;
        bus.melody_trig = mt;
        bus.bass_trig   = bt;
        @(posedge clk);
        m_bs = 0; m_ls = 0;
        if (rs) begin
            model_reset();
        end else if (ft && !h) begin
            if (m_tick + 1 == 6) begin
                m_tick = 0;
                m_bs   = 1;
                m_ls   = (m_pos == 287) ? 1 : 0;
                m_pos  = (m_pos == 287) ? 0 : m_pos + 1;
                if (mt) m_sv = 63;
                if (bt) m_bv = 63;
            end else begin
                m_tick = m_tick + 1;
                m_sv   = m_sv - (m_sv / 8);
                m_bv   = m_bv - (m_bv / 4);
            end
        end
        e.pos = songpos_t'(m_pos);
        e.sv  = vol_t'(m_sv);
        e.bv  = vol_t'(m_bv);
        e.bs  = m_bs[0];
        e.ls  = m_ls[0];
        q.push_back(e);
    endtask

    // Spaced tick: accepted tick followed by an idle cycle.
    task automatic tick(input logic mt, input logic bt);
        step(1'b1, 1'b0, 1'b0, mt, bt);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_songpos"}, int'(bus.songpos), 287);
        chk({tag, "_sqr_vol"}, int'(bus.sqr_vol), 0);
        chk({tag, "_bass_vol"}, int'(bus.bass_vol), 0);
        chk({tag, "_beat_strobe"}, int'(bus.beat_strobe), 0);
        chk({tag, "_loop_strobe"}, int'(bus.loop_strobe), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("songpos", int'(bus.songpos), int'(e.pos));
                chk("sqr_vol", int'(bus.sqr_vol), int'(e.sv));
                chk("bass_vol", int'(bus.bass_vol), int'(e.bv));
                chk("beat_strobe", int'(bus.beat_strobe), int'(e.bs));
                chk("loop_strobe", int'(bus.loop_strobe), int'(e.ls));
                if (bus.beat_strobe) n_beat++;
                if (bus.loop_strobe) n_loop++;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bus.frame_tick  = 1'b0;
        bus.hold        = 1'b0;
        bus.restart     = 1'b0;
        bus.melody_trig = 1'b0;
        bus.bass_trig   = 1'b0;
        #12;
        chk_reset_state("por");
        @(negedge clk);
        reset = 1'b0;

        // First beat lands on row 0 and arms both voices; then decay and hold.
        repeat (5) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("arm_sqr_vol", int'(bus.sqr_vol), 63);
        chk("arm_bass_vol", int'(bus.bass_vol), 63);
        repeat (5) tick(1'b0, 1'b0);
        chk("decay_sqr_vol", int'(bus.sqr_vol), 34);
        chk("decay_bass_vol", int'(bus.bass_vol), 16);
        tick(1'b0, 1'b0);
        chk("beat_hold_sqr_vol", int'(bus.sqr_vol), 34);

        // Hold across 10 ticks mid-beat, with triggers high to prove they are ignored.
        repeat (2) tick(1'b0, 1'b0);
        repeat (10) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        repeat (4) tick(1'b0, 1'b0);
        chk("hold_resume_songpos", int'(bus.songpos), 2);

        // Async reset mid-beat, then a full beat to row 0.
        repeat (3) tick(1'b0, 1'b0);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_state("async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);

        // Restart with hold on a beat-completing tick.
        repeat (5) tick(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back ticks: one beat to row 0, then a full song lap.
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        n_beat = 0;
        n_loop = 0;
        for (int i = 0; i < 288 * 6; i++)
            step(1'b1, 1'b0, 1'b0, (i % 7) == 0, (i % 11) == 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("lap_beats", n_beat, 288);
        chk("lap_loops", n_loop, 1);
        chk("lap_songpos", int'(bus.songpos), 0);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nyan_song_sequencer.md
# nyan_song_sequencer

Tick-driven song sequencer and envelope generator for the audio path. It counts video-frame ticks into beats and advances the song position through a looping song. On each beat it samples the melody/bass trigger ROM bits and re-arms per-voice volume envelopes; between beats it decays them. It sits directly upstream of the oscillator/mixer stage, which consumes `songpos`, `sqr_vol` and `bass_vol` to index note tables and scale square-wave samples.

## Interface
Parameters:
- `SONG_LEN`, 288: number of song rows; position wraps from `SONG_LEN-1` to 0.
- `TICKS_PER_BEAT`, 6: frame ticks per song row.
- `VOL_MAX`, 63: envelope re-arm value.
- `SQR_SHIFT`, 3: melody decay shift.
- `BASS_SHIFT`, 2: bass decay shift.

Ports:
- `clk` input 1: pixel clock.
- `reset` input 1: asynchronous, active-high reset.
- `frame_tick` input 1: one-cycle pulse once per frame, at the start of line 0. This is the sequencer tick.
- `hold` input 1: pauses the sequencer while high.
- `restart` input 1: one-cycle synchronous pulse that rewinds to the reset state.
- `melody_trig` input 1: ROM bit for the current `songpos`, valid combinationally.
- `bass_trig` input 1: ROM bit for the current `songpos`, valid combinationally.
- `songpos` output 9: current song row; also the ROM address.
- `sqr_vol` output 6: melody envelope.
- `bass_vol` output 6: bass envelope.
- `beat_strobe` output 1: high for one cycle when `songpos` advances.
- `loop_strobe` output 1: high for one cycle when `songpos` wraps to 0.

## Operation
- State: `tick_ctr` (3 bits), `songpos`, `sqr_vol`, `bass_vol`.
- Reset values:
  - `songpos = SONG_LEN-1`
  - `tick_ctr = 0`
  - `sqr_vol = 0`, `bass_vol = 0`
  - strobes 0
- The first beat after reset lands on row 0.
- Per accepted tick (`frame_tick & ~hold & ~restart`):
  - Compute `tick_next = tick_ctr + 1`.
  - Beat, when `tick_next == TICKS_PER_BEAT`:
    - `tick_ctr <= 0`.
    - `songpos <= (songpos == SONG_LEN-1) ? 0 : songpos+1`.
    - If `melody_trig` then `sqr_vol <= VOL_MAX`; else `sqr_vol` holds, with no decay on beat ticks.
    - `bass_trig` behaves the same way for `bass_vol`.
    - Triggers are sampled at the *old* `songpos`.
    - Pulse `beat_strobe`; pulse `loop_strobe` if the position wrapped.
  - Otherwise:
    - `tick_ctr <= tick_next`.
    - `sqr_vol <= sqr_vol - (sqr_vol >> SQR_SHIFT)`.
    - `bass_vol <= bass_vol - (bass_vol >> BASS_SHIFT)`.
- Envelope arithmetic is 6-bit unsigned and cannot underflow. Values below 2^shift stick at their value, which is intended.
- `hold` high: ticks are ignored and all state is frozen.
- `restart`: loads the reset values on the next edge and suppresses strobes. It wins over a coincident `frame_tick` and over `hold`.
- Async `reset` mid-beat: all state returns to reset values immediately. The next beat needs a full `TICKS_PER_BEAT` ticks.

## Timing
- All outputs are registered and change on the `clk` edge that samples the accepted `frame_tick`. Latency is 1 cycle from the tick.
- `beat_strobe` and `loop_strobe` are high exactly in the cycle in which the new `songpos` is first visible.
- `melody_trig` and `bass_trig` must be stable in the `frame_tick` cycle. The ROM is addressed combinationally by `songpos`.
- `frame_tick` pulses arriving on consecutive cycles are each accepted. There is no minimum spacing.

## Structure
- Shared package `nyan_audio_pkg` holds `SONG_LEN`, `TICKS_PER_BEAT` and `VOL_MAX` defaults, plus the 9-bit `songpos` and 6-bit volume typedefs reused by the mixer.
- Sub-module `nyan_env_decay` is instantiated twice:
  - Parameter: `SHIFT`.
  - Inputs: `clk`, `reset`, `tick`, `trig`, `beat`, `clr`.
  - Output: 6-bit `vol`.
  - Holds the re-arm/decay/hold logic for one voice.
- The top level owns `tick_ctr`, `songpos` and the strobes.

## Test plan
- Reset: assert `reset` mid-run -> `songpos=287`, vols 0, strobes 0 immediately. Six ticks later -> `songpos=0` with one `beat_strobe` and one `loop_strobe`.
- Melody decay: `melody_trig=1` at beat, then 5 non-beat ticks -> `sqr_vol` 63,56,49,43,38,34. It holds 34 at the next beat if `melody_trig=0`.
- Bass decay: `bass_trig=1` at beat, then 5 ticks -> `bass_vol` 63,48,36,27,21,16.
- Wrap: run 288 beats -> `songpos` sequence 0..287,0. `loop_strobe` fires only on the transition to 0; `beat_strobe` fires 288 times.
- Hold: `hold=1` across 10 ticks mid-beat -> `songpos`, `tick_ctr` and vols are unchanged. After release, the beat completes after the remaining ticks.
- Restart: `restart` coincident with a beat-completing `frame_tick` and `hold=1` -> `songpos=287`, vols 0, no strobe.
